fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Instruction-fetch PC generator and IF/ID slot that sits directly upstream of the branch predictor.
- Drives the fetch PC to instruction memory and to the predictor's lookup address.
- Consumes the predictor's registered taken/target outputs one cycle later, steers the next PC and squashes the sequential fall-through.
- Takes a higher-priority redirect from EX on a resolved misprediction.

Parameters:
PC_WIDTH, 32, width of all PC and target values
RESET_PC, 32'h0000_0000, fetch address after reset
INST_BYTES, 4, sequential PC increment; power of two
CNT_WIDTH, 16, width of the saturating statistics counters

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  hazard-unit stall; holds the PC and the ID slot
pred_taken_i  in  1  predictor taken output, registered, valid for the PC presented on pc_f_o in the previous cycle
pred_target_i  in  PC_WIDTH  predictor target output, same timing as pred_taken_i
ex_redirect_i  in  1  EX resolved a misprediction; flush and redirect
ex_redirect_pc_i  in  PC_WIDTH  correct PC from EX
pc_f_o  out  PC_WIDTH  fetch PC to imem (sync read, data aligned with the ID slot) and to the predictor lookup address
id_valid_o  out  1  ID slot holds a live instruction
id_pc_o  out  PC_WIDTH  PC of the ID-slot instruction
id_pred_taken_o  out  1  prediction bound to the ID-slot instruction
id_pred_target_o  out  PC_WIDTH  predicted target bound to the ID-slot instruction
redirect_count_o  out  CNT_WIDTH  predicted-taken redirects performed, saturating
flush_count_o  out  CNT_WIDTH  EX redirects performed, saturating

Behaviour:
Reset values (asynchronous on rst):
- pc_f = RESET_PC; id_valid = 0; id_pc = 0.
- held_taken = 0; held_target = 0; pred_fresh = 0.
- Both counters = 0.

Prediction binding:
- pred_fresh = 1 in the cycle right after the ID slot loads a new instruction.
- That is the only cycle in which the predictor outputs belong to id_pc.
- id_pred_taken_o = id_valid & (pred_fresh ? pred_taken_i : held_taken); this is combinational.
- id_pred_target_o = pred_fresh ? pred_target_i : held_target.

Next-state priority, evaluated every posedge:
1. ex_redirect_i:
   - pc_f <= ex_redirect_pc_i with the low log2(INST_BYTES) bits cleared.
   - id_valid <= 0; pred_fresh <= 0; flush_count +1 (saturating).
   - Overrides stall_i and any pending predicted redirect.
2. stall_i (no EX redirect):
   - pc_f, id_valid and id_pc hold.
   - If pred_fresh: held_taken/held_target <= id_pred outputs, then pred_fresh <= 0.
   - This preserves the prediction while the predictor looks up the held pc_f.
3. id_pred_taken_o (no stall):
   - pc_f <= id_pred_target_o.
   - id_valid <= 0; the fall-through at pc_f is squashed and a bubble enters ID.
   - pred_fresh <= 0; redirect_count +1 (saturating).
   - The branch itself leaves ID to EX normally. Taken-prediction penalty is exactly 1 bubble.
4. Otherwise (sequential):
   - id_valid <= 1; id_pc <= pc_f; pred_fresh <= 1.
   - pc_f <= pc_f + INST_BYTES, modulo 2^PC_WIDTH (wraps silently).

Other rules:
- Predicted not-taken or id_valid = 0: no redirect; held values are ignored.
- Deferred redirect: a prediction stalled in ID redirects on the first non-stalled cycle, using the held values. It fires exactly once, because ID is replaced by a bubble.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-operation discards the ID slot and any pending prediction.
- There are no bypass or forwarding paths from EX into the prediction.

Decomposition:
- Shared cpu package holds:
  - PC_WIDTH and INST_BYTES defaults;
  - the RESET_PC constant;
  - the fetch-priority encoding (EX_REDIRECT > STALL > PRED_REDIRECT > SEQ) as a local enum for waveform readability.
- One natural sub-module: sat_counter (parameter CNT_WIDTH; inputs clk, rst, inc; output count). It is instantiated twice.

Test Plan:
1. Reset, no stall, predictor outputs 0 -> pc_f_o 0x0, 0x4, 0x8, 0xC on successive cycles; id_valid_o 0 then 1; id_pc_o = 0x8 when pc_f_o = 0xC.
2. pred_taken_i=1, target 0x100 in the fresh cycle for id_pc 0x8 -> next cycle pc_f_o=0x100, id_valid_o=0, redirect_count_o=1; one cycle later id_pc_o=0x100.
3. stall_i=1 in the fresh cycle with pred_taken_i=1, target 0x200; predictor outputs drop to 0 on the next cycle; stall held 3 cycles -> id_pred_taken_o stays 1 and target stays 0x200; on release pc_f_o=0x200, redirect_count_o=1.
4. ex_redirect_i=1 with ex_redirect_pc_i=0x406, concurrent with stall_i=1 and a fresh taken prediction -> pc_f_o=0x404, id_valid_o=0, flush_count_o=1, redirect_count_o unchanged.
5. RESET_PC=0xFFFF_FFFC, no stall -> pc_f_o 0xFFFF_FFFC then 0x0000_0000; id_pc_o=0xFFFF_FFFC.
6. CNT_WIDTH=2, five EX redirects -> flush_count_o = 1, 2, 3, 3, 3; rst asserted mid-run -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU front-end definitions.
//   PC_WIDTH_DEFAULT   : default width of PC and target values
//   INST_BYTES_DEFAULT : default sequential fetch increment (power of two)
//   RESET_PC_DEFAULT   : default fetch address after reset
//   fetch_sel_e        : next-PC source, listed highest priority first
package fetch_pc_unit_pkg;

   localparam int                    PC_WIDTH_DEFAULT   = 32;
   localparam int                    INST_BYTES_DEFAULT = 4;
   localparam logic [31:0]           RESET_PC_DEFAULT   = 32'h0000_0000;

   typedef enum logic [1:0] {
      SEL_EX_REDIRECT   = 2'd0,
      SEL_STALL         = 2'd1,
      SEL_PRED_REDIRECT = 2'd2,
      SEL_SEQ           = 2'd3
   } fetch_sel_e;

endpackage

// File: rtl/fetch_pc_unit_sat_counter.sv
// Saturating event counter: increments once per cycle while inc_i is high and
// sticks at all-ones instead of wrapping.
//   clk, rst : clock, asynchronous active-high reset (clears to zero)
//   inc_i    : count this cycle
//   count_o  : current count
module sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc_i,
   output logic [CNT_WIDTH-1:0] count_o
);

   logic [CNT_WIDTH-1:0] count_q;

   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator and IF/ID slot feeding the branch predictor.
//   clk, rst           : clock, asynchronous active-high reset
//   stall_i            : hold PC and ID slot
//   pred_taken_i/target: registered predictor outputs for last cycle's pc_f_o
//   ex_redirect_i/pc_i : misprediction redirect from EX (highest priority)
//   pc_f_o             : fetch PC to imem and predictor lookup
//   id_valid_o, id_pc_o: ID slot contents
//   id_pred_taken_o/target_o : prediction bound to the ID instruction
//   redirect_count_o   : predicted-taken redirects (saturating)
//   flush_count_o      : EX redirects (saturating)
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int                  PC_WIDTH   = PC_WIDTH_DEFAULT,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int                  INST_BYTES = INST_BYTES_DEFAULT,
   parameter int                  CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 pred_taken_i,
   input  logic [PC_WIDTH-1:0]  pred_target_i,
   input  logic                 ex_redirect_i,
   input  logic [PC_WIDTH-1:0]  ex_redirect_pc_i,
   output logic [PC_WIDTH-1:0]  pc_f_o,
   output logic                 id_valid_o,
   output logic [PC_WIDTH-1:0]  id_pc_o,
   output logic                 id_pred_taken_o,
   output logic [PC_WIDTH-1:0]  id_pred_target_o,
   output logic [CNT_WIDTH-1:0] redirect_count_o,
   output logic [CNT_WIDTH-1:0] flush_count_o
);

   // Clears the byte-offset bits of an EX redirect target.
   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(INST_BYTES - 1));

   logic [PC_WIDTH-1:0] pc_f_q, pc_f_d;
   logic                id_valid_q, id_valid_d;
   logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;
   logic                held_taken_q, held_taken_d;
   logic [PC_WIDTH-1:0] held_target_q, held_target_d;
   logic                pred_fresh_q, pred_fresh_d;
   fetch_sel_e          sel;

   // The predictor answers one cycle after lookup, so its outputs belong to
   // the ID instruction only in the cycle right after ID was loaded; after
   // that a stalled prediction is served from the held copy.
   assign id_pred_taken_o  = id_valid_q & (pred_fresh_q ? pred_taken_i : held_taken_q);
   assign id_pred_target_o = pred_fresh_q ? pred_target_i : held_target_q;

   always_comb begin
      // NOTE: every signal driven here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      sel           = SEL_SEQ;
      pc_f_d        = pc_f_q;
      id_valid_d    = id_valid_q;
      id_pc_d       = id_pc_q;
      held_taken_d  = held_taken_q;
      held_target_d = held_target_q;
      pred_fresh_d  = pred_fresh_q;

      if (ex_redirect_i)        sel = SEL_EX_REDIRECT;
      else if (stall_i)         sel = SEL_STALL;
      else if (id_pred_taken_o) sel = SEL_PRED_REDIRECT;

      unique case (sel)
         SEL_EX_REDIRECT: begin
            pc_f_d       = ex_redirect_pc_i & ALIGN_MASK;
            id_valid_d   = 1'b0;
            pred_fresh_d = 1'b0;
         end
         SEL_STALL: begin
            // Capture the prediction before the predictor moves on to
            // looking up the (held) fetch PC.
            if (pred_fresh_q) begin
               held_taken_d  = id_pred_taken_o;
               held_target_d = id_pred_target_o;
               pred_fresh_d  = 1'b0;
            end
         end
         SEL_PRED_REDIRECT: begin
            // Squash the fall-through being fetched; the bubble in ID also
            // guarantees a deferred redirect fires only once.
            pc_f_d       = id_pred_target_o;
            id_valid_d   = 1'b0;
            pred_fresh_d = 1'b0;
         end
         default: begin
            id_valid_d   = 1'b1;
            id_pc_d      = pc_f_q;
            pred_fresh_d = 1'b1;
            pc_f_d       = pc_f_q + PC_WIDTH'(INST_BYTES);
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_f_q        <= RESET_PC;
         id_valid_q    <= 1'b0;
         id_pc_q       <= '0;
         held_taken_q  <= 1'b0;
         held_target_q <= '0;
         pred_fresh_q  <= 1'b0;
      end else begin
         pc_f_q        <= pc_f_d;
         id_valid_q    <= id_valid_d;
         id_pc_q       <= id_pc_d;
         held_taken_q  <= held_taken_d;
         held_target_q <= held_target_d;
         pred_fresh_q  <= pred_fresh_d;
      end
   end

   assign pc_f_o     = pc_f_q;
   assign id_valid_o = id_valid_q;
   assign id_pc_o    = id_pc_q;

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_redirect_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (sel == SEL_PRED_REDIRECT),
      .count_o (redirect_count_o)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (sel == SEL_EX_REDIRECT),
      .count_o (flush_count_o)
   );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit. Instance dut uses defaults; instance
// dut_b (RESET_PC = 0xFFFF_FFFC, CNT_WIDTH = 2) shares all stimulus and is
// checked for PC wrap and counter saturation. Counters in dut accumulate
// across steps until the mid-run reset.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        pred_taken_i;
   logic [31:0] pred_target_i;
   logic        ex_redirect_i;
   logic [31:0] ex_redirect_pc_i;

   logic [31:0] pc_f_o, id_pc_o, id_pred_target_o;
   logic        id_valid_o, id_pred_taken_o;
   logic [15:0] redirect_count_o, flush_count_o;

   logic [31:0] b_pc_f_o, b_id_pc_o, b_id_pred_target_o;
   logic        b_id_valid_o, b_id_pred_taken_o;
   logic [1:0]  b_redirect_count_o, b_flush_count_o;

   int checks_total  = 0;
   int checks_passed = 0;

   always #5 clk = ~clk;

   fetch_pc_unit dut (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall_i),
      .pred_taken_i     (pred_taken_i),
      .pred_target_i    (pred_target_i),
      .ex_redirect_i    (ex_redirect_i),
      .ex_redirect_pc_i (ex_redirect_pc_i),
      .pc_f_o           (pc_f_o),
      .id_valid_o       (id_valid_o),
      .id_pc_o          (id_pc_o),
      .id_pred_taken_o  (id_pred_taken_o),
      .id_pred_target_o (id_pred_target_o),
      .redirect_count_o (redirect_count_o),
      .flush_count_o    (flush_count_o)
   );

   fetch_pc_unit #(
      .RESET_PC  (32'hFFFF_FFFC),
      .CNT_WIDTH (2)
   ) dut_b (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall_i),
      .pred_taken_i     (pred_taken_i),
      .pred_target_i    (pred_target_i),
      .ex_redirect_i    (ex_redirect_i),
      .ex_redirect_pc_i (ex_redirect_pc_i),
      .pc_f_o           (b_pc_f_o),
      .id_valid_o       (b_id_valid_o),
      .id_pc_o          (b_id_pc_o),
      .id_pred_taken_o  (b_id_pred_taken_o),
      .id_pred_target_o (b_id_pred_target_o),
      .redirect_count_o (b_redirect_count_o),
      .flush_count_o    (b_flush_count_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      stall_i = 1'b0; pred_taken_i = 1'b0; pred_target_i = '0;
      ex_redirect_i = 1'b0; ex_redirect_pc_i = '0;

      // ---- reset state ----
      tick();
      check("rst_pc",        pc_f_o, 32'h0);
      check("rst_id_valid",  {31'b0, id_valid_o}, 32'h0);
      check("rst_id_pc",     id_pc_o, 32'h0);
      check("rst_redir_cnt", {16'b0, redirect_count_o}, 32'h0);
      check("rst_flush_cnt", {16'b0, flush_count_o}, 32'h0);
      rst = 1'b0;

      // ---- 1: sequential fetch ----
      tick();
      check("seq_pc4",    pc_f_o, 32'h4);
      check("seq_valid",  {31'b0, id_valid_o}, 32'h1);
      check("seq_idpc0",  id_pc_o, 32'h0);
      tick();
      check("seq_pc8",    pc_f_o, 32'h8);
      tick();
      check("seq_pcC",    pc_f_o, 32'hC);
      check("seq_idpc8",  id_pc_o, 32'h8);

      // ---- 2: fresh taken prediction for id_pc 0x8 ----
      pred_taken_i = 1'b1; pred_target_i = 32'h100;
      #1;
      check("pred_taken_comb", {31'b0, id_pred_taken_o}, 32'h1);
      check("pred_tgt_comb",   id_pred_target_o, 32'h100);
      tick();
      pred_taken_i = 1'b0; pred_target_i = '0;
      check("pred_pc",        pc_f_o, 32'h100);
      check("pred_bubble",    {31'b0, id_valid_o}, 32'h0);
      check("pred_redir_cnt", {16'b0, redirect_count_o}, 32'h1);
      tick();
      check("pred_idpc",      id_pc_o, 32'h100);
      check("pred_valid",     {31'b0, id_valid_o}, 32'h1);
      check("pred_pc_next",   pc_f_o, 32'h104);

      // ---- 3: prediction held across a 3-cycle stall ----
      stall_i = 1'b1; pred_taken_i = 1'b1; pred_target_i = 32'h200;
      tick();
      pred_taken_i = 1'b0; pred_target_i = '0;
      check("stall_taken_1", {31'b0, id_pred_taken_o}, 32'h1);
      check("stall_tgt_1",   id_pred_target_o, 32'h200);
      check("stall_pc_1",    pc_f_o, 32'h104);
      tick();
      check("stall_taken_2", {31'b0, id_pred_taken_o}, 32'h1);
      check("stall_tgt_2",   id_pred_target_o, 32'h200);
      tick();
      check("stall_taken_3", {31'b0, id_pred_taken_o}, 32'h1);
      check("stall_idpc_3",  id_pc_o, 32'h100);
      check("stall_cnt_3",   {16'b0, redirect_count_o}, 32'h1);
      stall_i = 1'b0;
      tick();
      check("defer_pc",        pc_f_o, 32'h200);
      check("defer_redir_cnt", {16'b0, redirect_count_o}, 32'h2);
      check("defer_bubble",    {31'b0, id_valid_o}, 32'h0);
      check("defer_once",      {31'b0, id_pred_taken_o}, 32'h0);
      tick();
      check("defer_idpc",      id_pc_o, 32'h200);
      check("defer_cnt_hold",  {16'b0, redirect_count_o}, 32'h2);

      // ---- 4: EX redirect beats stall and fresh taken prediction ----
      ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h406;
      stall_i = 1'b1; pred_taken_i = 1'b1; pred_target_i = 32'h300;
      tick();
      ex_redirect_i = 1'b0; stall_i = 1'b0; pred_taken_i = 1'b0; pred_target_i = '0;
      check("ex_pc",        pc_f_o, 32'h404);
      check("ex_bubble",    {31'b0, id_valid_o}, 32'h0);
      check("ex_flush_cnt", {16'b0, flush_count_o}, 32'h1);
      check("ex_redir_cnt", {16'b0, redirect_count_o}, 32'h2);
      tick();
      check("ex_idpc",      id_pc_o, 32'h404);
      check("ex_pc_next",   pc_f_o, 32'h408);

      // ---- 5: PC wrap from RESET_PC 0xFFFF_FFFC (dut_b) ----
      rst = 1'b1;
      #1;
      check("wrap_rst_pc",   b_pc_f_o, 32'hFFFF_FFFC);
      check("rst_async_cnt", {16'b0, flush_count_o}, 32'h0);
      tick();
      rst = 1'b0;
      check("wrap_pc0",      b_pc_f_o, 32'hFFFF_FFFC);
      tick();
      check("wrap_pc1",      b_pc_f_o, 32'h0);
      check("wrap_idpc",     b_id_pc_o, 32'hFFFF_FFFC);
      check("wrap_valid",    {31'b0, b_id_valid_o}, 32'h1);

      // ---- 6: flush counter saturation at CNT_WIDTH = 2 ----
      ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h40;
      tick(); check("sat_1", {30'b0, b_flush_count_o}, 32'h1);
      tick(); check("sat_2", {30'b0, b_flush_count_o}, 32'h2);
      tick(); check("sat_3", {30'b0, b_flush_count_o}, 32'h3);
      tick(); check("sat_4", {30'b0, b_flush_count_o}, 32'h3);
      tick(); check("sat_5", {30'b0, b_flush_count_o}, 32'h3);
      check("wide_cnt_5",    {16'b0, flush_count_o}, 32'h5);
      check("sat_pc",        b_pc_f_o, 32'h40);
      ex_redirect_i = 1'b0; ex_redirect_pc_i = '0;
      tick();
      check("pre_rst_valid", {31'b0, id_valid_o}, 32'h1);
      pred_taken_i = 1'b1; pred_target_i = 32'h80;
      #1;
      check("pre_rst_taken", {31'b0, id_pred_taken_o}, 32'h1);

      // Mid-cycle asynchronous reset, no clock edge before sampling.
      rst = 1'b1;
      #1;
      check("arst_pc",       pc_f_o, 32'h0);
      check("arst_b_pc",     b_pc_f_o, 32'hFFFF_FFFC);
      check("arst_valid",    {31'b0, id_valid_o}, 32'h0);
      check("arst_idpc",     id_pc_o, 32'h0);
      check("arst_taken",    {31'b0, id_pred_taken_o}, 32'h0);
      check("arst_tgt",      id_pred_target_o, 32'h0);
      check("arst_flush",    {16'b0, flush_count_o}, 32'h0);
      check("arst_b_flush",  {30'b0, b_flush_count_o}, 32'h0);
      check("arst_redir",    {16'b0, redirect_count_o}, 32'h0);
      pred_taken_i = 1'b0; pred_target_i = '0;
      rst = 1'b0;

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
